// File: rtl/gb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gb_pkg
// Description : Shared definitions for the Game Boy serial link block:
//               transfer state encoding, CPU register addresses and the
//               default bit-period dividers.
// Revision    : 1.0 - initial release
// ============================================================================
package gb_pkg;

    // Transfer state; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_XFER_INT = 2'd1,
        ST_XFER_EXT = 2'd2
    } gb_state_e;

    // CPU-visible register addresses (low byte of FF01 / FF02).
    localparam logic [7:0] ADDR_SB = 8'h01;
    localparam logic [7:0] ADDR_SC = 8'h02;

    // Default clk cycles per bit: 8192 Hz and 262144 Hz at 4.19 MHz.
    localparam int GB_DIV_NORMAL_DEF = 512;
    localparam int GB_DIV_FAST_DEF   = 16;

endpackage : gb_pkg
`default_nettype wire

// File: rtl/gb_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : gb_sync_edge
// Description : Two-flop synchroniser for an asynchronous input followed by
//               a rising/falling edge detector on the synchronised value.
// Ports       : clk     - system clock
//               reset   - synchronous active-high reset
//               async_i - asynchronous input (idle high)
//               rise_o  - one-clk pulse on a synchronised rising edge
//               fall_o  - one-clk pulse on a synchronised falling edge
// Revision    : 1.0 - initial release
// ============================================================================
module gb_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // All flops reset high so an idle-high link clock produces no edge
    // when reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule : gb_sync_edge
`default_nettype wire

// File: rtl/gb_serial.sv
`default_nettype none
// ============================================================================
// Module      : gb_serial
// Description : Game Boy serial link controller (SB/SC registers). Shifts
//               8 bits MSB-first using either an internal divided clock or
//               an external link clock, then raises a one-clk interrupt.
// Ports       : clk, reset            - system clock, sync active-high reset
//               cpu_sel_sb/cpu_sel_sc - CPU addressing SB (FF01) / SC (FF02)
//               cpu_wr, cpu_di        - write strobe and data
//               cpu_do                - combinational read data
//               irq                   - serial interrupt pulse
//               ser_clk_in            - external link clock (async)
//               ser_data_in           - link receive data
//               ser_clk_out           - internal link clock (idle high)
//               ser_data_out          - link transmit data
//               ser_clk_oe            - internal clock transfer active
// Revision    : 1.0 - initial release
// ============================================================================
module gb_serial
    import gb_pkg::*;
#(
    parameter int DIV_NORMAL = GB_DIV_NORMAL_DEF,
    parameter int DIV_FAST   = GB_DIV_FAST_DEF,
    parameter int CGB        = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_sel_sb,
    input  logic       cpu_sel_sc,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_di,
    output logic [7:0] cpu_do,
    output logic       irq,
    input  logic       ser_clk_in,
    input  logic       ser_data_in,
    output logic       ser_clk_out,
    output logic       ser_data_out,
    output logic       ser_clk_oe
);

    localparam int DIV_MAX = (DIV_NORMAL > DIV_FAST) ? DIV_NORMAL : DIV_FAST;
    localparam int DIV_W   = $clog2(DIV_MAX);

    localparam logic [DIV_W-1:0] NORM_LAST = DIV_W'(DIV_NORMAL - 1);
    localparam logic [DIV_W-1:0] NORM_HALF = DIV_W'(DIV_NORMAL / 2);
    localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(DIV_FAST - 1);
    localparam logic [DIV_W-1:0] FAST_HALF = DIV_W'(DIV_FAST / 2);

    gb_state_e        state_q, state_d;
    logic [7:0]       sb_q, sb_d;
    logic             start_q, start_d;
    logic             intclk_q, intclk_d;
    logic             fast_q, fast_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             irq_q, irq_d;
    logic             clk_out_q, clk_out_d;
    logic             data_out_q, data_out_d;

    logic             w_ext_rise;
    logic             w_ext_fall;
    logic             w_fast_wr;
    logic [7:0]       w_sc_rd;
    logic             w_done;
    logic [DIV_W-1:0] w_div_last;
    logic [DIV_W-1:0] w_div_half;

    gb_sync_edge u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (ser_clk_in),
        .rise_o  (w_ext_rise),
        .fall_o  (w_ext_fall)
    );

    // The fast bit only exists on CGB; on DMG it reads back as 1 and never
    // latches, so the normal divider is always used.
    generate
        if (CGB != 0) begin : g_fast_en
            assign w_fast_wr = cpu_di[1];
            assign w_sc_rd   = {start_q, 5'h1F, fast_q, intclk_q};
        end else begin : g_fast_dis
            assign w_fast_wr = 1'b0;
            assign w_sc_rd   = {start_q, 6'h3F, intclk_q};
        end
    endgenerate

    assign cpu_do = cpu_sel_sb ? sb_q :
                    cpu_sel_sc ? w_sc_rd : 8'hFF;

    assign w_div_last = fast_q ? FAST_LAST : NORM_LAST;
    assign w_div_half = fast_q ? FAST_HALF : NORM_HALF;

    // Internal clock: finish once the eighth bit period has fully elapsed
    // (divider wrapped back to 0). External clock: finish the cycle after
    // the eighth shift.
    assign w_done = (bitcnt_q == 4'd8) &&
                    ((state_q == ST_XFER_EXT) ||
                     ((state_q == ST_XFER_INT) && (div_q == '0)));

    always_comb begin
        state_d    = state_q;
        sb_d       = sb_q;
        start_d    = start_q;
        intclk_d   = intclk_q;
        fast_d     = fast_q;
        bitcnt_d   = bitcnt_q;
        div_d      = div_q;
        irq_d      = 1'b0;
        clk_out_d  = clk_out_q;
        data_out_d = data_out_q;

        if (w_done) begin
            state_d   = ST_IDLE;
            start_d   = 1'b0;
            irq_d     = 1'b1;
            clk_out_d = 1'b1;
        end else begin
            case (state_q)
                ST_XFER_INT: begin
                    if (div_q == '0) begin
                        clk_out_d  = 1'b0;
                        data_out_d = sb_q[7];
                    end else if (div_q == w_div_half) begin
                        clk_out_d = 1'b1;
                        sb_d      = {sb_q[6:0], ser_data_in};
                        bitcnt_d  = bitcnt_q + 4'd1;
                    end
                    div_d = (div_q == w_div_last) ? '0 : div_q + 1'b1;
                end
                ST_XFER_EXT: begin
                    if (w_ext_fall) begin
                        data_out_d = sb_q[7];
                    end else if (w_ext_rise) begin
                        sb_d     = {sb_q[6:0], ser_data_in};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end

        // CPU writes override whatever the shifter did this cycle; the
        // interrupt pulse from a coinciding completion is kept.
        if (cpu_wr && cpu_sel_sb) begin
            sb_d = cpu_di;
        end
        if (cpu_wr && cpu_sel_sc) begin
            start_d   = cpu_di[7];
            intclk_d  = cpu_di[0];
            fast_d    = w_fast_wr;
            bitcnt_d  = 4'd0;
            div_d     = '0;
            clk_out_d = 1'b1;
            if (!cpu_di[7]) begin
                state_d = ST_IDLE;
            end else if (cpu_di[0]) begin
                state_d = ST_XFER_INT;
            end else begin
                state_d = ST_XFER_EXT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sb_q       <= 8'h00;
            start_q    <= 1'b0;
            intclk_q   <= 1'b0;
            fast_q     <= 1'b0;
            bitcnt_q   <= 4'd0;
            div_q      <= '0;
            irq_q      <= 1'b0;
            clk_out_q  <= 1'b1;
            data_out_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            sb_q       <= sb_d;
            start_q    <= start_d;
            intclk_q   <= intclk_d;
            fast_q     <= fast_d;
            bitcnt_q   <= bitcnt_d;
            div_q      <= div_d;
            irq_q      <= irq_d;
            clk_out_q  <= clk_out_d;
            data_out_q <= data_out_d;
        end
    end

    assign irq          = irq_q;
    assign ser_clk_out  = clk_out_q;
    assign ser_data_out = data_out_q;
    assign ser_clk_oe   = (state_q == ST_XFER_INT);

endmodule : gb_serial
`default_nettype wire

// File: tb/tb_gb_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_gb_serial
// Description : Self-checking bench for gb_serial. A DMG instance and a CGB
//               instance share all stimulus; register vectors come from a
//               table, transfers from hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gb_serial;

    logic       clk;
    logic       reset;
    logic       sel_sb;
    logic       sel_sc;
    logic       wr;
    logic [7:0] di;
    logic       ser_clk_in;
    logic       ser_data_in;

    logic [7:0] do_dmg, do_cgb;
    logic       irq_dmg, irq_cgb;
    logic       sco_dmg, sco_cgb;
    logic       sdo_dmg, sdo_cgb;
    logic       oe_dmg, oe_cgb;

    int n_checks = 0;
    int n_errors = 0;

    // Transfer observation (relative to the most recent clear_watch)
    int   cyc;
    int   n_fall;
    int   fall_cyc[16];
    logic fall_bit[16];
    int   n_irq;
    int   irq_cyc;
    int   oe_hi;
    logic prev_sco;

    gb_serial #(.DIV_NORMAL(512), .DIV_FAST(16), .CGB(0)) u_dmg (
        .clk(clk), .reset(reset), .cpu_sel_sb(sel_sb), .cpu_sel_sc(sel_sc),
        .cpu_wr(wr), .cpu_di(di), .cpu_do(do_dmg), .irq(irq_dmg),
        .ser_clk_in(ser_clk_in), .ser_data_in(ser_data_in),
        .ser_clk_out(sco_dmg), .ser_data_out(sdo_dmg), .ser_clk_oe(oe_dmg)
    );

    gb_serial #(.DIV_NORMAL(512), .DIV_FAST(16), .CGB(1)) u_cgb (
        .clk(clk), .reset(reset), .cpu_sel_sb(sel_sb), .cpu_sel_sc(sel_sc),
        .cpu_wr(wr), .cpu_di(di), .cpu_do(do_cgb), .irq(irq_cgb),
        .ser_clk_in(ser_clk_in), .ser_data_in(ser_data_in),
        .ser_clk_out(sco_cgb), .ser_data_out(sdo_cgb), .ser_clk_oe(oe_cgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       s_sb;
        logic       s_sc;
        logic       w;
        logic [7:0] d;
        logic [7:0] exp_dmg;
        logic [7:0] exp_cgb;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic cpu_write(input bit to_sc, input logic [7:0] data);
        sel_sb = !to_sc;
        sel_sc = to_sc;
        wr     = 1'b1;
        di     = data;
        tick();
        sel_sb = 1'b0;
        sel_sc = 1'b0;
        wr     = 1'b0;
        di     = 8'h00;
    endtask

    task automatic rd(input bit from_sc, output logic [7:0] d_dmg, output logic [7:0] d_cgb);
        sel_sb = !from_sc;
        sel_sc = from_sc;
        #1;
        d_dmg  = do_dmg;
        d_cgb  = do_cgb;
        sel_sb = 1'b0;
        sel_sc = 1'b0;
    endtask

    task automatic clear_watch(input bit use_cgb);
        cyc      = 0;
        n_fall   = 0;
        n_irq    = 0;
        irq_cyc  = -1;
        oe_hi    = 0;
        prev_sco = use_cgb ? sco_cgb : sco_dmg;
    endtask

    task automatic run_watch(input bit use_cgb, input int ncyc);
        logic c_sco, c_sdo, c_irq, c_oe;
        for (int n = 0; n < ncyc; n++) begin
            tick();
            cyc++;
            c_sco = use_cgb ? sco_cgb : sco_dmg;
            c_sdo = use_cgb ? sdo_cgb : sdo_dmg;
            c_irq = use_cgb ? irq_cgb : irq_dmg;
            c_oe  = use_cgb ? oe_cgb  : oe_dmg;
            if (prev_sco && !c_sco) begin
                if (n_fall < 16) begin
                    fall_cyc[n_fall] = cyc;
                    fall_bit[n_fall] = c_sdo;
                end
                n_fall++;
            end
            if (c_irq) begin
                if (n_irq == 0) irq_cyc = cyc;
                n_irq++;
            end
            if (c_oe) oe_hi++;
            prev_sco = c_sco;
        end
    endtask

    initial begin : main
        logic [7:0] rd_dmg, rd_cgb;
        logic [7:0] pat;
        logic [7:0] ext_pat;

        reset = 1'b1; sel_sb = 1'b0; sel_sc = 1'b0; wr = 1'b0; di = 8'h00;
        ser_clk_in = 1'b1; ser_data_in = 1'b1;
        do_reset();

        // ---------------- reset state ----------------
        check("reset ser_clk_out", {31'd0, sco_dmg}, 32'd1);
        check("reset ser_data_out", {31'd0, sdo_dmg}, 32'd1);
        check("reset irq", {31'd0, irq_dmg}, 32'd0);
        check("reset ser_clk_oe", {31'd0, oe_dmg}, 32'd0);

        // ---------------- register access table ----------------
        // cpu_do is checked before the edge, so it shows pre-write state.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h7E, 8'h7C};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'h5A, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h5A, 8'h5A};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h7E, 8'h7C};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h02, 8'h7E, 8'h7C};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h7E, 8'h7E};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h01, 8'h7E, 8'h7E};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h7F, 8'h7D};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF};
        for (int i = 0; i < 11; i++) begin
            sel_sb = vecs[i].s_sb;
            sel_sc = vecs[i].s_sc;
            wr     = vecs[i].w;
            di     = vecs[i].d;
            #1;
            check($sformatf("vec%0d dmg cpu_do", i), {24'd0, do_dmg}, {24'd0, vecs[i].exp_dmg});
            check($sformatf("vec%0d cgb cpu_do", i), {24'd0, do_cgb}, {24'd0, vecs[i].exp_cgb});
            tick();
        end
        sel_sb = 1'b0; sel_sc = 1'b0; wr = 1'b0; di = 8'h00;

        // ---------------- internal clock transfer ----------------
        do_reset();
        ser_data_in = 1'b1;
        cpu_write(1'b0, 8'hA5);
        cpu_write(1'b1, 8'h81);
        clear_watch(1'b0);
        run_watch(1'b0, 4200);
        pat = 8'hA5;
        check("int fall count", n_fall, 8);
        for (int k = 0; k < 8; k++) begin
            if (k < n_fall) begin
                check($sformatf("int fall%0d cycle", k), fall_cyc[k], 1 + 512 * k);
                check($sformatf("int fall%0d bit", k), {31'd0, fall_bit[k]}, {31'd0, pat[7-k]});
            end
        end
        check("int irq count", n_irq, 1);
        check("int irq cycle", irq_cyc, 8 * 512 + 1);
        check("int oe cycles", oe_hi, 8 * 512);
        check("int clk_out idle", {31'd0, sco_dmg}, 32'd1);
        rd(1'b0, rd_dmg, rd_cgb);
        check("int SB", {24'd0, rd_dmg}, 32'hFF);
        rd(1'b1, rd_dmg, rd_cgb);
        check("int SC", {24'd0, rd_dmg}, 32'h7F);

        // ---------------- external clock transfer ----------------
        do_reset();
        cpu_write(1'b1, 8'h80);
        cpu_write(1'b0, 8'h3C);
        clear_watch(1'b0);
        run_watch(1'b0, 20);
        rd(1'b1, rd_dmg, rd_cgb);
        check("ext waiting SC", {24'd0, rd_dmg}, 32'hFE);
        ext_pat = 8'h96;
        for (int b = 7; b >= 0; b--) begin
            ser_clk_in = 1'b0;
            run_watch(1'b0, 4);
            ser_data_in = ext_pat[b];
            run_watch(1'b0, 4);
            ser_clk_in = 1'b1;
            run_watch(1'b0, 6);
        end
        run_watch(1'b0, 10);
        check("ext irq count", n_irq, 1);
        check("ext oe cycles", oe_hi, 0);
        check("ext clk_out falls", n_fall, 0);
        rd(1'b0, rd_dmg, rd_cgb);
        check("ext SB", {24'd0, rd_dmg}, 32'h96);
        rd(1'b1, rd_dmg, rd_cgb);
        check("ext SC", {24'd0, rd_dmg}, 32'h7E);
        ser_data_in = 1'b1;

        // ---------------- abort after 3 bits ----------------
        do_reset();
        cpu_write(1'b1, 8'h81);
        clear_watch(1'b0);
        run_watch(1'b0, 1599);
        check("abort pre clk_out low", {31'd0, sco_dmg}, 32'd0);
        cpu_write(1'b1, 8'h01);
        check("abort clk_out", {31'd0, sco_dmg}, 32'd1);
        rd(1'b1, rd_dmg, rd_cgb);
        check("abort SC", {24'd0, rd_dmg}, 32'h7F);
        rd(1'b0, rd_dmg, rd_cgb);
        check("abort SB partial", {24'd0, rd_dmg}, 32'h07);
        clear_watch(1'b0);
        run_watch(1'b0, 5000);
        check("abort irq count", n_irq, 0);
        check("abort clk_out falls", n_fall, 0);

        // ---------------- CGB fast mode ----------------
        do_reset();
        cpu_write(1'b1, 8'h83);
        rd(1'b1, rd_dmg, rd_cgb);
        check("fast SC running", {24'd0, rd_cgb}, 32'hFF);
        clear_watch(1'b1);
        run_watch(1'b1, 200);
        check("fast irq count", n_irq, 1);
        check("fast irq cycle", irq_cyc, 129);
        check("fast fall count", n_fall, 8);
        check("fast fall1 cycle", fall_cyc[1], 17);
        rd(1'b1, rd_dmg, rd_cgb);
        check("fast SC done", {24'd0, rd_cgb}, 32'h7F);

        // SB write on the same edge as the first shift wins
        do_reset();
        cpu_write(1'b1, 8'h83);
        clear_watch(1'b1);
        run_watch(1'b1, 8);
        cpu_write(1'b0, 8'h42);
        rd(1'b0, rd_dmg, rd_cgb);
        check("sb write over shift", {24'd0, rd_cgb}, 32'h42);

        // SC restart on the completion edge still pulses irq
        do_reset();
        cpu_write(1'b1, 8'h83);
        clear_watch(1'b1);
        run_watch(1'b1, 128);
        check("coincide pre irq", n_irq, 0);
        cpu_write(1'b1, 8'h83);
        check("coincide irq", {31'd0, irq_cgb}, 32'd1);
        rd(1'b1, rd_dmg, rd_cgb);
        check("coincide SC restarted", {24'd0, rd_cgb}, 32'hFF);
        clear_watch(1'b1);
        run_watch(1'b1, 140);
        check("coincide second irq cycle", irq_cyc, 129);

        // ---------------- reset mid-transfer ----------------
        do_reset();
        cpu_write(1'b0, 8'hA5);
        cpu_write(1'b1, 8'h81);
        clear_watch(1'b0);
        run_watch(1'b0, 2150);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(1'b0, rd_dmg, rd_cgb);
        check("rst mid SB", {24'd0, rd_dmg}, 32'h00);
        rd(1'b1, rd_dmg, rd_cgb);
        check("rst mid SC dmg", {24'd0, rd_dmg}, 32'h7E);
        check("rst mid SC cgb", {24'd0, rd_cgb}, 32'h7C);
        check("rst mid clk_out", {31'd0, sco_dmg}, 32'd1);
        clear_watch(1'b0);
        run_watch(1'b0, 20);
        check("rst mid irq count", n_irq, 0);
        cpu_write(1'b1, 8'h81);
        clear_watch(1'b0);
        run_watch(1'b0, 4200);
        check("rst follow irq count", n_irq, 1);
        check("rst follow irq cycle", irq_cyc, 4097);
        rd(1'b0, rd_dmg, rd_cgb);
        check("rst follow SB", {24'd0, rd_dmg}, 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_gb_serial
`default_nettype wire
